ex_mdu: RTL and testbench

Multi-cycle RV32M execute unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It sits beside the combinational EX stage and is started when the decoded opcode is `INST_TYPE_R_M` with funct7 = 7'b000_0001. It stalls the pipeline through `hold_flag_o` until the result is ready, then writes the result back to regs. Datapath width and divider radix are parametrised.

---
 rtl/ex_mdu_pkg.sv | 59 +++++
 rtl/mdu_div_step.sv | 38 +++
 rtl/ex_mdu.sv | 221 ++++++++++++++++++++++
 tb/tb_ex_mdu.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit (ex_mdu).
// funct3 codes, the M-extension funct7, FSM state encoding and common
// enable constants live here so the decoder and the unit agree on them.
package ex_mdu_pkg;

  // funct3 operation select for the M extension
  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  // funct7 that marks an R-type instruction as belonging to the M extension
  localparam logic [6:0] INST_FUNCT7_M = 7'b000_0001;

  // Common pipeline constants
  localparam logic [31:0] ZeroWord     = 32'h0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic        HoldEnable   = 1'b1;
  localparam logic        HoldDisable  = 1'b0;

  // Unit state encoding
  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  // op[2] separates the divide family from the multiply family
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // DIV and REM treat their operands as signed; DIVU and REMU do not
  function automatic logic op_div_signed(input logic [2:0] op);
    return op[2] & ~op[0];
  endfunction

  // REM/REMU return the remainder, DIV/DIVU the quotient
  function automatic logic op_is_rem(input logic [2:0] op);
    return op[1];
  endfunction

  // MULH and MULHSU sign-extend rs1
  function automatic logic op_mul_a_signed(input logic [2:0] op);
    return (op == INST_MULH) || (op == INST_MULHSU);
  endfunction

  // Only MULH sign-extends rs2
  function automatic logic op_mul_b_signed(input logic [2:0] op);
    return op == INST_MULH;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// Combinational restoring-division slice for ex_mdu.
// Performs DIV_BITS unsigned restoring steps in a chain. The quotient
// register doubles as the dividend shift register: each step shifts the
// next dividend bit out of its MSB into the partial remainder and shifts
// the new quotient bit into its LSB.
module mdu_div_step #(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 1
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN-1:0] rem_c [DIV_BITS+1];
  logic [XLEN-1:0] quo_c [DIV_BITS+1];

  assign rem_c[0] = rem_i;
  assign quo_c[0] = quo_i;

  for (genvar gi = 0; gi < DIV_BITS; gi++) begin : g_step
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Partial remainder is always below the divisor, so the shifted value
    // fits in XLEN+1 bits and the borrow bit says whether it subtracts.
    assign shifted        = {rem_c[gi], quo_c[gi][XLEN-1]};
    assign diff           = shifted - {1'b0, dsr_i};
    assign rem_c[gi+1]    = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_c[gi+1]    = {quo_c[gi][XLEN-2:0], ~diff[XLEN]};
  end

  assign rem_o = rem_c[DIV_BITS];
  assign quo_o = quo_c[DIV_BITS];

endmodule

// File: rtl/ex_mdu.sv
// Multi-cycle RV32M execute unit: MUL/MULH/MULHSU/MULHU in one cycle,
// DIV/DIVU/REM/REMU by restoring division, DIV_BITS quotient bits per cycle.
// Optional feature macro MDU_EARLY_OUT_EN: divide-by-zero and signed
// overflow skip the iterative DIV state and go straight to DONE.
// Results are identical with and without the macro.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wen_o,
  output logic            busy_o,
  output logic            hold_flag_o
);

  localparam int              STEPS    = XLEN / DIV_BITS;
  localparam int              CNT_W    = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS);
  localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  // FSM and captured request
  mdu_state_e       state_q;
  logic [2:0]       op_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [4:0]       rd_q;

  // Division datapath
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             div_zero_q;
  logic             ovf_q;
  logic             q_neg_q;
  logic             r_neg_q;

  // Registered writeback outputs
  logic             wen_q;
  logic [XLEN-1:0]  data_q;
  logic [4:0]       addr_q;

  // Combinational helpers
  logic             in_signed;
  logic             in_dz;
  logic             in_ovf;
  logic             in_a_neg;
  logic             in_b_neg;
  logic [XLEN-1:0]  in_a_mag;
  logic [XLEN-1:0]  in_b_mag;
  logic signed [XLEN:0]     mul_a;
  logic signed [XLEN:0]     mul_b;
  logic signed [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]  mul_res;
  logic [XLEN-1:0]  rem_step;
  logic [XLEN-1:0]  quo_step;
  logic [XLEN-1:0]  quo_fix;
  logic [XLEN-1:0]  rem_fix;
  logic [XLEN-1:0]  div_res;

  // Mandated result for the two division corner cases; shared by the
  // early-out path and the end-of-iteration fix-up so both agree.
  function automatic logic [XLEN-1:0] special_res(input logic [2:0] op,
                                                  input logic [XLEN-1:0] op1,
                                                  input logic dz);
    if (dz) return op_is_rem(op) ? op1 : '1;
    return op_is_rem(op) ? '0 : op1;
  endfunction

  // Classify the incoming request: signedness, corner cases, magnitudes.
  always_comb begin
    in_signed = op_div_signed(op_i);
    in_dz     = (op2_i == '0);
    in_ovf    = in_signed && (op1_i == XMIN) && (op2_i == '1);
    in_a_neg  = in_signed & op1_i[XLEN-1];
    in_b_neg  = in_signed & op2_i[XLEN-1];
    in_a_mag  = in_a_neg ? -op1_i : op1_i;
    in_b_mag  = in_b_neg ? -op2_i : op2_i;
  end

  // Multiply (XLEN+1)-bit extended operands; the low 2*XLEN bits of the
  // product are exact for every signedness combination.
  always_comb begin
    mul_a    = {op_mul_a_signed(op_q) & a_q[XLEN-1], a_q};
    mul_b    = {op_mul_b_signed(op_q) & b_q[XLEN-1], b_q};
    mul_prod = mul_a * mul_b;
    mul_res  = (op_q == INST_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  end

  mdu_div_step #(
    .XLEN     (XLEN),
    .DIV_BITS (DIV_BITS)
  ) u_div_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dsr_i (dsr_q),
    .rem_o (rem_step),
    .quo_o (quo_step)
  );

  // Sign fix-up of the finished magnitudes; corner cases override.
  always_comb begin
    quo_fix = q_neg_q ? -quo_q : quo_q;
    rem_fix = r_neg_q ? -rem_q : rem_q;
    if (div_zero_q || ovf_q) begin
      div_res = special_res(op_q, a_q, div_zero_q);
    end else begin
      div_res = op_is_rem(op_q) ? rem_fix : quo_fix;
    end
  end

  // Unit FSM: capture, multiply, iterate divide, one-cycle writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= MDU_IDLE;
      op_q       <= 3'b000;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= 5'd0;
      rem_q      <= '0;
      quo_q      <= '0;
      dsr_q      <= '0;
      cnt_q      <= '0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      wen_q      <= WriteDisable;
      data_q     <= '0;
      addr_q     <= 5'd0;
    end else begin
      wen_q  <= WriteDisable;
      data_q <= '0;
      addr_q <= 5'd0;
      case (state_q)
        MDU_IDLE: begin
          if (start_i && !flush_i) begin
            op_q       <= op_i;
            a_q        <= op1_i;
            b_q        <= op2_i;
            rd_q       <= rd_addr_i;
            rem_q      <= '0;
            quo_q      <= in_a_mag;
            dsr_q      <= in_b_mag;
            div_zero_q <= in_dz;
            ovf_q      <= in_ovf;
            q_neg_q    <= in_a_neg ^ in_b_neg;
            r_neg_q    <= in_a_neg;
            if (!op_is_div(op_i)) begin
              state_q <= MDU_MUL;
`ifdef MDU_EARLY_OUT_EN
            end else if (in_dz || in_ovf) begin
              state_q <= MDU_DONE;
              wen_q   <= WriteEnable;
              data_q  <= special_res(op_i, op1_i, in_dz);
              addr_q  <= rd_addr_i;
`endif
            end else begin
              state_q <= MDU_DIV;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        MDU_MUL: begin
          if (flush_i) begin
            state_q <= MDU_IDLE;
          end else begin
            state_q <= MDU_DONE;
            wen_q   <= WriteEnable;
            data_q  <= mul_res;
            addr_q  <= rd_q;
          end
        end
        MDU_DIV: begin
          if (flush_i) begin
            state_q <= MDU_IDLE;
          end else if (cnt_q == '0) begin
            state_q <= MDU_DONE;
            wen_q   <= WriteEnable;
            data_q  <= div_res;
            addr_q  <= rd_q;
          end else begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        MDU_DONE: begin
          state_q <= MDU_IDLE;
        end
        default: begin
          state_q <= MDU_IDLE;
        end
      endcase
    end
  end

  // A flush arriving in DONE must still cancel the writeback of that cycle.
  assign rd_wen_o  = wen_q & ~flush_i;
  assign rd_data_o = flush_i ? '0 : data_q;
  assign rd_addr_o = flush_i ? 5'd0 : addr_q;
  assign busy_o    = (state_q != MDU_IDLE);

  // Stall starts in the request cycle and drops in DONE so the pipeline
  // advances while the result is written.
  assign hold_flag_o = ((start_i && (state_q == MDU_IDLE) && !flush_i) ||
                        (state_q == MDU_MUL) || (state_q == MDU_DIV)) ?
                       HoldEnable : HoldDisable;

endmodule

// File: tb/tb_ex_mdu.sv
// Directed testbench for ex_mdu with default parameters (XLEN=32, DIV_BITS=1).
module tb_ex_mdu;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_wen_o;
  logic        busy_o;
  logic        hold_flag_o;

  int checks = 0;
  int errors = 0;

`ifdef MDU_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 0;
`else
  localparam int SPECIAL_LAT = 33;
`endif

  ex_mdu #(.XLEN(32), .DIV_BITS(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .op_i        (op_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .rd_addr_i   (rd_addr_i),
    .flush_i     (flush_i),
    .rd_addr_o   (rd_addr_o),
    .rd_data_o   (rd_data_o),
    .rd_wen_o    (rd_wen_o),
    .busy_o      (busy_o),
    .hold_flag_o (hold_flag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait (bounded) for the writeback and check it.
  // Latency is counted in clock edges after the accepting edge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_data, input int exp_lat);
    int lat;
    int hold_cnt;
    int dirty;
    logic seen;
    logic [31:0] data;
    logic [4:0]  addr;
    @(negedge clk);
    start_i = 1'b1; op_i = op; op1_i = a; op2_i = b; rd_addr_i = rd;
    #1;
    chk({tag, "_hold_req"}, {31'd0, hold_flag_o}, 32'd1);
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 0; hold_cnt = 0; dirty = 0; seen = 1'b0; data = '0; addr = '0;
    while (!seen && lat < 100) begin
      if (rd_wen_o) begin
        seen = 1'b1;
        data = rd_data_o;
        addr = rd_addr_o;
        chk({tag, "_hold_done"}, {31'd0, hold_flag_o}, 32'd0);
      end else begin
        if (hold_flag_o) hold_cnt++;
        if (rd_data_o != 0 || rd_addr_o != 0) dirty++;
        @(posedge clk); #1;
        lat++;
      end
    end
    chk({tag, "_data"}, data, exp_data);
    chk({tag, "_addr"}, {27'd0, addr}, {27'd0, rd});
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_hold_cycles"}, hold_cnt, exp_lat);
    chk({tag, "_quiet"}, dirty, 0);
    @(posedge clk); #1;
    chk({tag, "_wen_pulse"}, {30'd0, rd_wen_o, busy_o}, 32'd0);
  endtask

  initial begin
    int wen_cnt;
    rst = 1'b0; start_i = 1'b0; op_i = 3'b000; op1_i = '0; op2_i = '0;
    rd_addr_i = '0; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {29'd0, rd_wen_o, busy_o, hold_flag_o}, 32'd0);
    chk("reset_data", rd_data_o, 32'd0);
    chk("reset_addr", {27'd0, rd_addr_o}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ctrl", {29'd0, rd_wen_o, busy_o, hold_flag_o}, 32'd0);

    // Multiply family
    run_op("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 1);
    run_op("mulhu_min",  3'b011, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 1);
    run_op("mul_min",    3'b000, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h0000_0000, 1);
    run_op("mulhsu_min", 3'b010, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'hC000_0000, 1);
    run_op("mul_neg",    3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 5'd5, 32'hFFFF_FFEB, 1);

    // Divide family, ordinary operands
    run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 33);
    run_op("divu_big",   3'b101, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'h7FFF_FFFC, 33);
    run_op("remu_big",   3'b111, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'h0000_0001, 33);
    run_op("div_7_m2",   3'b100, 32'd7, 32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD, 33);
    run_op("rem_7_m2",   3'b110, 32'd7, 32'hFFFF_FFFE, 5'd11, 32'h0000_0001, 33);

    // Divide by zero and signed overflow
    run_op("divu_z",     3'b101, 32'h1234, 32'd0, 5'd12, 32'hFFFF_FFFF, SPECIAL_LAT);
    run_op("remu_z",     3'b111, 32'h1234, 32'd0, 5'd13, 32'h0000_1234, SPECIAL_LAT);
    run_op("div_neg_z",  3'b100, 32'hFFFF_FFFB, 32'd0, 5'd14, 32'hFFFF_FFFF, SPECIAL_LAT);
    run_op("rem_neg_z",  3'b110, 32'hFFFF_FFFB, 32'd0, 5'd15, 32'hFFFF_FFFB, SPECIAL_LAT);
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, SPECIAL_LAT);
    run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, SPECIAL_LAT);

    // Flush mid-division; a start during the division is ignored
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b101; op1_i = 32'd100; op2_i = 32'd3; rd_addr_i = 5'd18;
    @(posedge clk); #1;
    start_i = 1'b0;
    wen_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (rd_wen_o) wen_cnt++;
      if (k == 5) begin
        start_i = 1'b1; op_i = 3'b000; op1_i = 32'd2; op2_i = 32'd2; rd_addr_i = 5'd19;
      end
      if (k == 6) start_i = 1'b0;
    end
    chk("flush_busy_before", {31'd0, busy_o}, 32'd1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_idle", {30'd0, busy_o, hold_flag_o}, 32'd0);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (rd_wen_o) wen_cnt++;
    end
    chk("flush_no_wb", wen_cnt, 0);

    // Flush together with start in IDLE: not accepted
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'b000; op1_i = 32'd4; op2_i = 32'd4;
    #1;
    chk("flush_start_hold", {31'd0, hold_flag_o}, 32'd0);
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_start_busy", {31'd0, busy_o}, 32'd0);

    // Unit still healthy after the aborted division
    run_op("divu_after", 3'b101, 32'd100, 32'd7, 5'd20, 32'd14, 33);

    // Asynchronous reset in the middle of a division
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b100; op1_i = 32'd1000; op2_i = 32'd10; rd_addr_i = 5'd21;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_ctrl", {29'd0, rd_wen_o, busy_o, hold_flag_o}, 32'd0);
    chk("rst_mid_data", rd_data_o, 32'd0);
    chk("rst_mid_addr", {27'd0, rd_addr_o}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    wen_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (rd_wen_o || busy_o) wen_cnt++;
    end
    chk("rst_no_wb", wen_cnt, 0);
    run_op("mul_3x5",    3'b000, 32'd3, 32'd5, 5'd22, 32'd15, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
